// File: rtl/permutator_pkg.sv
// Shared types and sizing for the permutator network.
// Lane count is a power of two so the lane index and the permutation cfg share one width.
package permutator_pkg;

   localparam int LOG2SLICES = 3;
   localparam int SLICES     = 1 << LOG2SLICES;
   localparam int DATA_WIDTH = 32;

   typedef logic [DATA_WIDTH-1:0]        lane_t;
   typedef logic [LOG2SLICES-1:0]        cfg_t;
   typedef logic [LOG2SLICES-1:0]        idx_t;
   typedef logic [SLICES-1:0]            mask_t;
   typedef logic [SLICES*DATA_WIDTH-1:0] vec_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } loader_state_e;

endpackage

// File: rtl/permutator_loader_if.sv
// Word-stream ingress and lane-vector egress of the permutator loader.
//   t_dat/t_cfg/t_last/t_valid/t_ready       : one word per handshake into the loader
//   lanes_dat/cfg/mask/valid, lanes_ready    : assembled vector towards the permutator array
// master : the side feeding words and consuming vectors
// slave  : the loader itself
interface permutator_loader_if import permutator_pkg::*; ();

   lane_t t_dat;
   cfg_t  t_cfg;
   logic  t_last;
   logic  t_valid;
   logic  t_ready;
   vec_t  lanes_dat;
   cfg_t  lanes_cfg;
   mask_t lanes_mask;
   logic  lanes_valid;
   logic  lanes_ready;

   modport master (
      output t_dat, t_cfg, t_last, t_valid, lanes_ready,
      input  t_ready, lanes_dat, lanes_cfg, lanes_mask, lanes_valid
   );

   modport slave (
      input  t_dat, t_cfg, t_last, t_valid, lanes_ready,
      output t_ready, lanes_dat, lanes_cfg, lanes_mask, lanes_valid
   );

endinterface

// File: rtl/permutator_lane_buf.sv
// SLICES-lane register bank with a per-lane valid mask.
//   clk, rstn       : clock, asynchronous active-low reset
//   ld_en/ld_dat/ld_mask : load the whole bank (highest priority)
//   clr             : zero all lanes and the mask
//   wr_en/wr_idx/wr_dat  : write one lane and set its mask bit
//   lanes, mask     : current contents
module permutator_lane_buf import permutator_pkg::*; (
   input  logic  clk,
   input  logic  rstn,
   input  logic  clr,
   input  logic  wr_en,
   input  idx_t  wr_idx,
   input  lane_t wr_dat,
   input  logic  ld_en,
   input  vec_t  ld_dat,
   input  mask_t ld_mask,
   output vec_t  lanes,
   output mask_t mask
);

   // A write issued together with clr lands on top of the cleared bank,
   // so clear-and-start-new-vector works in a single edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lanes <= '0;
         mask  <= '0;
      end else if (ld_en) begin
         lanes <= ld_dat;
         mask  <= ld_mask;
      end else begin
         if (clr) begin
            lanes <= '0;
            mask  <= '0;
         end
         if (wr_en) begin
            lanes[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= wr_dat;
            mask[wr_idx]                           <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/permutator_loader.sv
// Ingress stage of the permutator network: packs up to SLICES consecutive words
// (word k -> lane k) into one lane vector with its cfg and a lane-valid mask.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : permutator_loader_if.slave (word stream in, lane vector out)
// A fill buffer collects words while a one-entry output register presents the
// previous vector. When the output slot is free the completing word is merged
// straight into the output register on the edge that accepts it; otherwise the
// completed vector parks in the fill buffer (FULL) and input stalls.
module permutator_loader import permutator_pkg::*; (
   input logic                 clk,
   input logic                 rstn,
   permutator_loader_if.slave  bus
);

   loader_state_e state, state_nxt;
   idx_t  count;
   cfg_t  fill_cfg, out_cfg, nxt_cfg;
   logic  out_valid;
   vec_t  fill_lanes, out_lanes, nxt_lanes;
   mask_t fill_mask, out_mask, nxt_mask;
   logic  t_ready_int, out_ld, fill_clr, fill_wr;
   logic  accept, last_word, slot_free;

   assign last_word = bus.t_last | (count == idx_t'(SLICES-1));
   assign slot_free = !out_valid | bus.lanes_ready;
   assign accept    = (state == FILL) & bus.t_valid;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= FILL;
      else       state <= state_nxt;
   end

   // Next state: park in FULL only when a vector completes but the output slot is taken.
   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL: if (bus.t_valid && last_word && !slot_free) state_nxt = FULL;
         FULL: if (slot_free)                              state_nxt = FILL;
      endcase
   end

   // Outputs: the completing word bypasses the fill buffer when the slot is free,
   // so the fill buffer is cleared instead of written on that edge.
   always_comb begin
      t_ready_int = 1'b0;
      out_ld      = 1'b0;
      fill_clr    = 1'b0;
      fill_wr     = 1'b0;
      unique case (state)
         FILL: begin
            t_ready_int = 1'b1;
            if (bus.t_valid && last_word && slot_free) begin
               out_ld   = 1'b1;
               fill_clr = 1'b1;
            end else begin
               fill_wr  = bus.t_valid;
            end
         end
         FULL: begin
            if (slot_free) begin
               out_ld   = 1'b1;
               fill_clr = 1'b1;
            end
         end
      endcase
   end

   // Vector headed for the output register: fill contents plus any word accepted now.
   always_comb begin
      nxt_lanes = fill_lanes;
      nxt_mask  = fill_mask;
      nxt_cfg   = fill_cfg;
      if (accept) begin
         nxt_lanes[count*DATA_WIDTH +: DATA_WIDTH] = bus.t_dat;
         nxt_mask[count]                           = 1'b1;
         if (count == '0) nxt_cfg = bus.t_cfg;
      end
   end

   // Lane index and cfg of the vector being filled; cfg only follows the first word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count    <= '0;
         fill_cfg <= '0;
      end else if (accept) begin
         count <= last_word ? '0 : count + idx_t'(1);
         if (count == '0) fill_cfg <= bus.t_cfg;
      end
   end

   // Output register control: a load on the handshake edge replaces the old vector with no bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_cfg   <= '0;
      end else if (out_ld) begin
         out_valid <= 1'b1;
         out_cfg   <= nxt_cfg;
      end else if (bus.lanes_ready) begin
         out_valid <= 1'b0;
      end
   end

   permutator_lane_buf u_fill_buf (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (fill_clr),
      .wr_en   (fill_wr),
      .wr_idx  (count),
      .wr_dat  (bus.t_dat),
      .ld_en   (1'b0),
      .ld_dat  ('0),
      .ld_mask ('0),
      .lanes   (fill_lanes),
      .mask    (fill_mask)
   );

   permutator_lane_buf u_out_buf (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (1'b0),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_dat  ('0),
      .ld_en   (out_ld),
      .ld_dat  (nxt_lanes),
      .ld_mask (nxt_mask),
      .lanes   (out_lanes),
      .mask    (out_mask)
   );

   assign bus.t_ready     = t_ready_int;
   assign bus.lanes_dat   = out_lanes;
   assign bus.lanes_cfg   = out_cfg;
   assign bus.lanes_mask  = out_mask;
   assign bus.lanes_valid = out_valid;

endmodule
